// File: rtl/tx_frame_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tx_frame_sched                                                 |
// | Brief   : Frame-level round-robin scheduler feeding one MAC TX stream,   |
// |           with inter-frame gap insertion and stalled-frame abort.        |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tx_frame_sched #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IFG = 12,
  parameter int TMO = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  input  logic [N-1:0]   src_v,
  input  logic [N*W-1:0] src_d,
  input  logic [N-1:0]   src_eof,
  output logic           v_o,
  output logic [W-1:0]   d_o,
  output logic           eof_o,
  output logic           err_o,
  output logic           busy
);

  localparam int c_PW = (N > 1) ? $clog2(N) : 1;
  localparam int c_GW = $clog2(IFG + 1);
  localparam int c_SW = $clog2(TMO + 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_XFER = 2'd1;
  localparam logic [1:0] c_GAP  = 2'd2;

  localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'(IFG - 1);
  localparam logic [c_SW-1:0] c_TMO_LAST = c_SW'(TMO - 1);
  localparam logic [c_PW-1:0] c_PTR_INIT = c_PW'(N - 1);

  logic [1:0]      r_state;
  logic [N-1:0]    r_gnt;
  logic [c_PW-1:0] r_ptr;
  logic [c_SW-1:0] r_stall;
  logic [c_GW-1:0] r_gap;
  logic            r_v;
  logic [W-1:0]    r_d;
  logic            r_eof;
  logic            r_err;

  logic            w_found;
  logic [c_PW-1:0] w_sel;
  logic [N-1:0]    w_onehot;
  logic            w_sv;
  logic            w_seof;
  logic [W-1:0]    w_sd;

  // Round-robin pick: scan upward starting just past the last granted source.
  always_comb begin : p_sel
    int idx;
    w_found = 1'b0;
    w_sel   = r_ptr;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(r_ptr) + k) % N;
      if (!w_found && req[idx]) begin
        w_found = 1'b1;
        w_sel   = c_PW'(idx);
      end
    end
  end

  assign w_onehot = {{(N-1){1'b0}}, 1'b1} << w_sel;

  // r_ptr also serves as the granted index for the whole frame.
  always_comb begin
    w_sv   = 1'b0;
    w_seof = 1'b0;
    w_sd   = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(r_ptr) == i) begin
        w_sv   = src_v[i];
        w_seof = src_eof[i];
        w_sd   = src_d[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
      r_gnt   <= '0;
      r_ptr   <= c_PTR_INIT;
      r_stall <= '0;
      r_gap   <= '0;
      r_v     <= 1'b0;
      r_d     <= '0;
      r_eof   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_v   <= 1'b0;
      r_eof <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_found) begin
            r_gnt   <= w_onehot;
            r_ptr   <= w_sel;
            r_stall <= '0;
            r_state <= c_XFER;
          end
        end
        c_XFER: begin
          if (w_sv) begin
            r_v     <= 1'b1;
            r_d     <= w_sd;
            r_eof   <= w_seof;
            r_stall <= '0;
            if (w_seof) begin
              r_gnt   <= '0;
              r_gap   <= '0;
              r_state <= c_GAP;
            end
          end else if (r_stall == c_TMO_LAST) begin
            // Abort without eof; the MAC sees only the error pulse.
            r_err   <= 1'b1;
            r_gnt   <= '0;
            r_stall <= '0;
            r_gap   <= '0;
            r_state <= c_GAP;
          end else begin
            r_stall <= r_stall + 1'b1;
          end
        end
        c_GAP: begin
          if (r_gap == c_GAP_LAST) begin
            r_gap   <= '0;
            r_state <= c_IDLE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign v_o   = r_v;
  assign d_o   = r_d;
  assign eof_o = r_eof;
  assign err_o = r_err;
  assign busy  = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tx_frame_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_tx_frame_sched                                              |
// | Brief   : Directed self-checking bench for tx_frame_sched (N=4, W=8).   |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_tx_frame_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [3:0]  src_v;
  logic [31:0] src_d;
  logic [3:0]  src_eof;
  logic        v_o;
  logic [7:0]  d_o;
  logic        eof_o;
  logic        err_o;
  logic        busy;

  int checks = 0;
  int errors = 0;

  tx_frame_sched #(.N(4), .W(8), .IFG(12), .TMO(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .src_v   (src_v),
    .src_d   (src_d),
    .src_eof (src_eof),
    .v_o     (v_o),
    .d_o     (d_o),
    .eof_o   (eof_o),
    .err_o   (err_o),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic v, input logic [7:0] d, input logic e);
    src_v   = '0;
    src_eof = '0;
    src_d   = '0;
    if (v) begin
      src_v[s]         = 1'b1;
      src_eof[s]       = e;
      src_d[s*8 +: 8]  = d;
    end
  endtask

  task automatic wait_gnt(output int k);
    k = 0;
    do begin
      tick();
      k++;
    end while (gnt == 4'b0 && k < 100);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 100) begin
      tick();
      k++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req = '0;
    set_src(0, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    checks++;
    if ({gnt, v_o, d_o, eof_o, err_o, busy} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b v=%b d=%h eof=%b err=%b busy=%b expected all zero",
               gnt, v_o, d_o, eof_o, err_o, busy);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_no_req: got gnt=%b busy=%b expected 0000/0", gnt, busy);
    end
  endtask

  task automatic test_single_source();
    int k;
    int vbad;
    req = 4'b0001;
    wait_gnt(k);
    checks++;
    if (gnt !== 4'b0001 || k !== 1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL t1_grant: got gnt=%b after %0d cycles busy=%b expected 0001 after 1 busy=1", gnt, k, busy);
    end
    for (int b = 0; b < 5; b++) begin
      if (b == 4) req = 4'b0000;
      set_src(0, 1'b1, 8'(8'h11 + b), (b == 4));
      tick();
      checks++;
      if (v_o !== 1'b1 || d_o !== 8'(8'h11 + b) || eof_o !== (b == 4)) begin
        errors++;
        $display("FAIL t1_byte%0d: got v=%b d=%h eof=%b expected v=1 d=%h eof=%b",
                 b, v_o, d_o, eof_o, 8'(8'h11 + b), (b == 4));
      end
    end
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL t1_gnt_drop_on_eof: got %b expected 0000", gnt);
    end
    set_src(0, 1'b0, 8'h00, 1'b0);
    k = 0;
    vbad = 0;
    while (busy && k < 50) begin
      tick();
      k++;
      if (v_o !== 1'b0 || eof_o !== 1'b0) vbad++;
    end
    checks++;
    if (k !== 12 || vbad !== 0) begin
      errors++;
      $display("FAIL t1_gap_len: got %0d gap cycles (%0d with v_o) expected 12 (0)", k, vbad);
    end
  endtask

  task automatic test_round_robin();
    int k;
    int s;
    logic [7:0] dv;
    do_reset();
    req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      s = f % 4;
      wait_gnt(k);
      checks++;
      if (gnt !== 4'(1 << s)) begin
        errors++;
        $display("FAIL t2_order_f%0d: got gnt=%b expected %b", f, gnt, 4'(1 << s));
      end
      if (f > 0) begin
        checks++;
        if (k !== 13) begin
          errors++;
          $display("FAIL t2_gap_f%0d: got %0d cycles eof-to-grant expected 13", f, k);
        end
      end
      if (f == 4) req = 4'b0000;
      for (int b = 0; b < 3; b++) begin
        dv = 8'(8'h10 * (s + 1) + b);
        set_src(s, 1'b1, dv, (b == 2));
        tick();
      end
      checks++;
      if (v_o !== 1'b1 || eof_o !== 1'b1 || d_o !== 8'(8'h10 * (s + 1) + 2)) begin
        errors++;
        $display("FAIL t2_eof_f%0d: got v=%b d=%h eof=%b expected v=1 d=%h eof=1",
                 f, v_o, d_o, eof_o, 8'(8'h10 * (s + 1) + 2));
      end
      set_src(0, 1'b0, 8'h00, 1'b0);
    end
    wait_idle();
  endtask

  task automatic test_timeout();
    int k;
    int bad;
    int eofs;
    req = 4'b0100;
    wait_gnt(k);
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL t3_grant: got %b expected 0100", gnt);
    end
    eofs = 0;
    set_src(2, 1'b1, 8'h41, 1'b0);
    tick();
    set_src(2, 1'b1, 8'h42, 1'b0);
    tick();
    checks++;
    if (v_o !== 1'b1 || d_o !== 8'h42) begin
      errors++;
      $display("FAIL t3_bytes: got v=%b d=%h expected v=1 d=42", v_o, d_o);
    end
    set_src(0, 1'b0, 8'h00, 1'b0);
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (err_o !== 1'b0 || gnt !== 4'b0100 || v_o !== 1'b0) bad++;
      if (eof_o !== 1'b0) eofs++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL t3_early_abort: got %0d bad stall cycles expected 0", bad);
    end
    tick();
    if (eof_o !== 1'b0) eofs++;
    checks++;
    if (err_o !== 1'b1 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL t3_abort: got err=%b gnt=%b expected err=1 gnt=0000", err_o, gnt);
    end
    req = 4'b1100;
    tick();
    if (eof_o !== 1'b0) eofs++;
    checks++;
    if (err_o !== 1'b0 || eofs !== 0) begin
      errors++;
      $display("FAIL t3_err_pulse: got err=%b eof_count=%0d expected err=0 eof_count=0", err_o, eofs);
    end
    wait_gnt(k);
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL t3_next_rr: got %b expected 1000", gnt);
    end
    req = 4'b0000;
    set_src(3, 1'b1, 8'h77, 1'b1);
    tick();
    checks++;
    if (v_o !== 1'b1 || eof_o !== 1'b1 || d_o !== 8'h77 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL t3_single_byte: got v=%b eof=%b d=%h gnt=%b expected 1 1 77 0000", v_o, eof_o, d_o, gnt);
    end
    set_src(0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_stall_below_tmo();
    int k;
    int bad;
    req = 4'b0010;
    wait_gnt(k);
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL t4_grant: got %b expected 0010", gnt);
    end
    req = 4'b0000;
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (err_o !== 1'b0 || gnt !== 4'b0010) bad++;
    end
    set_src(1, 1'b1, 8'hAB, 1'b1);
    tick();
    checks++;
    if (bad !== 0 || err_o !== 1'b0 || v_o !== 1'b1 || d_o !== 8'hAB || eof_o !== 1'b1) begin
      errors++;
      $display("FAIL t4_late_eof: got bad=%0d err=%b v=%b d=%h eof=%b expected 0 0 1 ab 1",
               bad, err_o, v_o, d_o, eof_o);
    end
    set_src(0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_non_granted_ignored();
    int k;
    logic [3:0]  vv [3];
    logic [3:0]  ee [3];
    logic [31:0] dd [3];
    logic        ev [3];
    logic [7:0]  ed [3];
    logic        eo [3];
    vv[0] = 4'b0011; ee[0] = 4'b0001; dd[0] = 32'h0000_31FF; ev[0] = 1'b1; ed[0] = 8'h31; eo[0] = 1'b0;
    vv[1] = 4'b0001; ee[1] = 4'b0001; dd[1] = 32'h0000_00FF; ev[1] = 1'b0; ed[1] = 8'h31; eo[1] = 1'b0;
    vv[2] = 4'b0011; ee[2] = 4'b0010; dd[2] = 32'h0000_32FF; ev[2] = 1'b1; ed[2] = 8'h32; eo[2] = 1'b1;
    req = 4'b0010;
    wait_gnt(k);
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL t5_grant: got %b expected 0010", gnt);
    end
    req = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      src_v   = vv[c];
      src_eof = ee[c];
      src_d   = dd[c];
      tick();
      checks++;
      if (v_o !== ev[c] || d_o !== ed[c] || eof_o !== eo[c]) begin
        errors++;
        $display("FAIL t5_cycle%0d: got v=%b d=%h eof=%b expected v=%b d=%h eof=%b",
                 c, v_o, d_o, eof_o, ev[c], ed[c], eo[c]);
      end
    end
    set_src(0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_midframe_reset();
    int k;
    req = 4'b0001;
    wait_gnt(k);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL t6_grant: got %b expected 0001", gnt);
    end
    set_src(0, 1'b1, 8'h5A, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({gnt, v_o, d_o, eof_o, err_o, busy} !== 16'h0) begin
      errors++;
      $display("FAIL t6_async_reset: got gnt=%b v=%b d=%h eof=%b err=%b busy=%b expected all zero",
               gnt, v_o, d_o, eof_o, err_o, busy);
    end
    set_src(0, 1'b0, 8'h00, 1'b0);
    tick();
    rst = 1'b1;
    req = 4'b0011;
    tick();
    checks++;
    if (gnt !== 4'b0001 || eof_o !== 1'b0) begin
      errors++;
      $display("FAIL t6_after_reset: got gnt=%b eof=%b expected 0001 0", gnt, eof_o);
    end
  endtask

  initial begin
    rst     = 1'b0;
    req     = '0;
    src_v   = '0;
    src_d   = '0;
    src_eof = '0;
    test_reset();
    test_single_source();
    test_round_robin();
    test_timeout();
    test_stall_below_tmo();
    test_non_granted_ignored();
    test_midframe_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
